// File: rtl/btb_multi_if.sv
// btb_multi_if: groups the lookup, tracking-stall and resolution signals of the BTB.
// Latency: none (wires only).
// Backpressure: hold_i stalls prediction tracking; the resolution path is never backpressured.
interface btb_multi_if #(
    parameter int ADDR_W = 32
);
    logic              hold_i;
    logic [ADDR_W-1:0] pc_i;
    logic              jmp_prediction_o;
    logic [ADDR_W-1:0] target_pc_o;
    logic              hit_o;
    logic              upd_valid_i;
    logic [ADDR_W-1:0] upd_pc_i;
    logic              upd_taken_i;
    logic [ADDR_W-1:0] upd_target_i;
    logic              prediction_error_o;

    modport master (
        output hold_i, pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
        input  jmp_prediction_o, target_pc_o, hit_o, prediction_error_o
    );

    modport slave (
        input  hold_i, pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
        output jmp_prediction_o, target_pc_o, hit_o, prediction_error_o
    );
endinterface

// File: rtl/btb_multi.sv
// btb_multi: direct-mapped BTB, 2-bit counters, one-stage prediction tracking, mispredict flag.
// Latency: lookup and error flag combinational; table/tracking state changes on the next clk edge.
// Backpressure: none; hold_i only freezes tracking. BTB_FLUSH_EN adds flush_i.
module btb_multi #(
    parameter int ADDR_W  = 32,
    parameter int ENTRIES = 16
) (
    input logic clk,
    input logic rst_n,
`ifdef BTB_FLUSH_EN
    input logic flush_i,
`endif
    btb_multi_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [ADDR_W-1:0] target;
        logic [1:0]        cnt;
    } entry_t;

    typedef struct packed {
        logic              pred;
        logic [ADDR_W-1:0] tgt;
        logic              hit;
    } trk_t;

    localparam entry_t RST_ENT = '{valid: 1'b0, tag: '0, target: '0, cnt: 2'b01};

    entry_t tbl [ENTRIES];
    trk_t   trk;

    logic flush;
`ifdef BTB_FLUSH_EN
    assign flush = flush_i;
`else
    assign flush = 1'b0;
`endif

    // Lookup path
    logic [IDX_W-1:0]  l_idx;
    logic [TAG_W-1:0]  l_tag;
    entry_t            l_ent;
    logic              l_hit;
    logic              l_pred;
    logic [ADDR_W-1:0] l_tgt;

    assign l_idx  = bus.pc_i[IDX_W+1:2];
    assign l_tag  = bus.pc_i[ADDR_W-1:IDX_W+2];
    assign l_ent  = tbl[l_idx];
    assign l_hit  = l_ent.valid && (l_ent.tag == l_tag);
    assign l_pred = l_hit && l_ent.cnt[1];
    assign l_tgt  = l_pred ? l_ent.target : '0;

    assign bus.hit_o            = l_hit;
    assign bus.jmp_prediction_o = l_pred;
    assign bus.target_pc_o      = l_tgt;

    assign bus.prediction_error_o = bus.upd_valid_i &&
        ((bus.upd_taken_i != trk.pred) ||
         (bus.upd_taken_i && (bus.upd_target_i != trk.tgt)));

    // Resolution path
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    entry_t           u_ent;
    logic             u_hit;
    entry_t           upd_ent;
    logic             upd_we;

    assign u_idx = bus.upd_pc_i[IDX_W+1:2];
    assign u_tag = bus.upd_pc_i[ADDR_W-1:IDX_W+2];
    assign u_ent = tbl[u_idx];
    assign u_hit = u_ent.valid && (u_ent.tag == u_tag);

    always_comb begin
        upd_ent = u_ent;
        upd_we  = 1'b0;
        if (bus.upd_valid_i) begin
            if (u_hit) begin
                upd_we = 1'b1;
                if (bus.upd_taken_i) begin
                    if (u_ent.cnt != 2'b11) upd_ent.cnt = u_ent.cnt + 2'b01;
                    upd_ent.target = bus.upd_target_i;
                end else if (u_ent.cnt != 2'b00) begin
                    upd_ent.cnt = u_ent.cnt - 2'b01;
                end
            end else if (bus.upd_taken_i) begin
                // Allocation evicts whatever aliased into this slot.
                upd_we  = 1'b1;
                upd_ent = '{valid: 1'b1, tag: u_tag, target: bus.upd_target_i, cnt: 2'b10};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) tbl[i] <= RST_ENT;
            trk <= '0;
        end else if (flush) begin
            // Tags and targets are left stale; clearing valid is enough.
            for (int i = 0; i < ENTRIES; i++) begin
                tbl[i].valid <= 1'b0;
                tbl[i].cnt   <= 2'b01;
            end
            trk <= '0;
        end else begin
            if (upd_we) tbl[u_idx] <= upd_ent;
            if (!bus.hold_i) trk <= '{pred: l_pred, tgt: l_tgt, hit: l_hit};
        end
    end

    logic unused_bits;
    assign unused_bits = ^{bus.pc_i[1:0], bus.upd_pc_i[1:0], trk.hit};
endmodule
